// File: rtl/ats21_pkg.sv
// ats21_pkg: shared types and constants for the ATS21 command issuer.
//   opcode_t       - ATS21 command opcodes (cmd[31:29])
//   NOP_CMD        - padding command for an empty channel
//   issuer_state_t - issuer FSM states
package ats21_pkg;

    typedef enum logic [2:0] {
        NOP       = 3'b000,
        SET_CLK   = 3'b001,
        CLK_EN    = 3'b010,
        SET_MODE  = 3'b011,
        SET_ALARM = 3'b101,
        SET_TIMER = 3'b110,
        AT_EN     = 3'b111
    } opcode_t;

    localparam logic [31:0] NOP_CMD = 32'h0000_0000;

    typedef enum logic [1:0] {IDLE, UPPER, LOWER} issuer_state_t;

endpackage

// File: rtl/ats21_cmd_fifo.sv
// ats21_cmd_fifo: synchronous FIFO holding commands for one issuer channel.
//   clk, reset      - clock, synchronous active-high reset (flushes contents)
//   push, din       - write request and data; ignored while full
//   pop, dout       - read request and head data; ignored while empty
//   full, empty     - occupancy flags derived from the registered level
//   level           - number of stored entries
module ats21_cmd_fifo
    import ats21_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ats21_cmd_issuer.sv
// ats21_cmd_issuer: pairs channel A/B command FIFO heads and sends each pair as two 16-bit beats.
//   clk, reset             - clock, synchronous active-high reset
//   a_valid/a_cmd/a_ready  - channel A command push interface
//   b_valid/b_cmd/b_ready  - channel B command push interface
//   req/ctrlA/ctrlB/ready  - beat handshake toward the responder (upper half, then lower half)
//   busy                   - FSM not idle
//   a_level/b_level        - FIFO occupancies
//   sent_cnt               - completed command pairs (wrapping)
//   err                    - one-cycle timeout abort pulse
// Optional feature macro ATS21_CMD_TIMEOUT_EN: abandon a pair after TIMEOUT stalled cycles on one beat.
module ats21_cmd_issuer
    import ats21_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       a_valid,
    input  logic [31:0]                a_cmd,
    output logic                       a_ready,
    input  logic                       b_valid,
    input  logic [31:0]                b_cmd,
    output logic                       b_ready,
    output logic                       req,
    output logic [15:0]                ctrlA,
    output logic [15:0]                ctrlB,
    input  logic                       ready,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     a_level,
    output logic [$clog2(DEPTH):0]     b_level,
    output logic [15:0]                sent_cnt,
    output logic                       err
);

    issuer_state_t state;
    logic [31:0]   h_a;
    logic [31:0]   h_b;
    logic [31:0]   a_dout;
    logic [31:0]   b_dout;
    logic [31:0]   next_a;
    logic [31:0]   next_b;
    logic          a_full;
    logic          b_full;
    logic          a_empty;
    logic          b_empty;
    logic          load;
    logic          abort;

    ats21_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo_a (
        .clk(clk), .reset(reset), .push(a_valid), .din(a_cmd),
        .pop(load && !a_empty), .dout(a_dout), .full(a_full), .empty(a_empty), .level(a_level)
    );

    ats21_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo_b (
        .clk(clk), .reset(reset), .push(b_valid), .din(b_cmd),
        .pop(load && !b_empty), .dout(b_dout), .full(b_full), .empty(b_empty), .level(b_level)
    );

    assign a_ready = !a_full;
    assign b_ready = !b_full;
    assign busy    = state != IDLE;
    assign next_a  = a_empty ? NOP_CMD : a_dout;
    assign next_b  = b_empty ? NOP_CMD : b_dout;
    // A new pair is taken from idle, or straight after the lower beat is accepted so
    // back-to-back pairs leave no req gap.
    assign load    = (!a_empty || !b_empty) && (state == IDLE || (state == LOWER && ready));

`ifdef ATS21_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    // Abort on the edge that would bring the stall count up to TIMEOUT; a beat
    // accepted on that edge wins because ready masks the abort.
    assign abort = req && !ready && (tmo_cnt == TW'(TIMEOUT - 1));
    always_ff @(posedge clk) begin
        if (reset || !req || ready || abort) tmo_cnt <= '0;
        else tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    localparam int tmo_unused = TIMEOUT;
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            h_a      <= NOP_CMD;
            h_b      <= NOP_CMD;
            req      <= 1'b0;
            ctrlA    <= '0;
            ctrlB    <= '0;
            sent_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= abort;
            if (abort) begin
                state <= IDLE;
                req   <= 1'b0;
                ctrlA <= '0;
                ctrlB <= '0;
            end else if (load) begin
                if (state == LOWER) sent_cnt <= sent_cnt + 1'b1;
                state <= UPPER;
                h_a   <= next_a;
                h_b   <= next_b;
                req   <= 1'b1;
                ctrlA <= next_a[31:16];
                ctrlB <= next_b[31:16];
            end else if (state == UPPER && ready) begin
                state <= LOWER;
                ctrlA <= h_a[15:0];
                ctrlB <= h_b[15:0];
            end else if (state == LOWER && ready) begin
                sent_cnt <= sent_cnt + 1'b1;
                state    <= IDLE;
                req      <= 1'b0;
                ctrlA    <= '0;
                ctrlB    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ats21_cmd_issuer.sv
// tb_ats21_cmd_issuer: directed self-checking bench for ats21_cmd_issuer (DEPTH=4).
module tb_ats21_cmd_issuer;

`ifdef ATS21_CMD_TIMEOUT_EN
    localparam int TMO   = 8;
    localparam int STALL = 4;
`else
    localparam int TMO   = 255;
    localparam int STALL = 7;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic [31:0] a_cmd = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [31:0] b_cmd = '0;
    logic        b_ready;
    logic        req;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic        ready = 1'b1;
    logic        busy;
    logic [2:0]  a_level;
    logic [2:0]  b_level;
    logic [15:0] sent_cnt;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] a_vec [5];
    logic [31:0] b_vec [5];

    ats21_cmd_issuer #(.DEPTH(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_cmd(a_cmd), .a_ready(a_ready),
        .b_valid(b_valid), .b_cmd(b_cmd), .b_ready(b_ready),
        .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB), .ready(ready),
        .busy(busy), .a_level(a_level), .b_level(b_level),
        .sent_cnt(sent_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        a_vec[0] = 32'h5F80_00FF;
        b_vec[0] = 32'hB000_B100;
        for (int k = 1; k < 5; k++) begin
            a_vec[k] = {8'hA0, 8'(k), 8'hA1, 8'(k)};
            b_vec[k] = {8'hB0, 8'(k), 8'hB1, 8'(k)};
        end

        // reset state
        step();
        step();
        chk("rst_req", 32'(req), 0);
        chk("rst_ctrlA", 32'(ctrlA), 0);
        chk("rst_ctrlB", 32'(ctrlB), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_a_ready", 32'(a_ready), 1);
        chk("rst_b_ready", 32'(b_ready), 1);
        chk("rst_a_level", 32'(a_level), 0);
        chk("rst_sent", 32'(sent_cnt), 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b0;

        // single A command, B padded with NOP
        a_valid = 1'b1;
        a_cmd = 32'h2A00_1234;
        step();
        a_valid = 1'b0;
        chk("s1_level", 32'(a_level), 1);
        chk("s1_req0", 32'(req), 0);
        step();
        chk("s1_up_req", 32'(req), 1);
        chk("s1_up_A", 32'(ctrlA), 32'h2A00);
        chk("s1_up_B", 32'(ctrlB), 0);
        chk("s1_busy", 32'(busy), 1);
        chk("s1_popped", 32'(a_level), 0);
        step();
        chk("s1_lo_req", 32'(req), 1);
        chk("s1_lo_A", 32'(ctrlA), 32'h1234);
        chk("s1_lo_B", 32'(ctrlB), 0);
        step();
        chk("s1_done_req", 32'(req), 0);
        chk("s1_done_busy", 32'(busy), 0);
        chk("s1_sent", 32'(sent_cnt), 1);
        chk("s1_ctrlA0", 32'(ctrlA), 0);

        // fill both FIFOs while the first pair stalls on its upper beat
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_valid = 1'b1;
            b_valid = 1'b1;
            a_cmd = a_vec[k];
            b_cmd = b_vec[k];
            step();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("fill_a_level", 32'(a_level), 4);
        chk("fill_b_level", 32'(b_level), 4);
        chk("fill_a_ready", 32'(a_ready), 0);
        chk("fill_b_ready", 32'(b_ready), 0);
        for (int i = 0; i < STALL; i++) begin
            step();
            chk("stall_req", 32'(req), 1);
            chk("stall_A", 32'(ctrlA), 32'h5F80);
            chk("stall_B", 32'(ctrlB), 32'hB000);
        end
        chk("stall_err", 32'(err), 0);

        // push into the full FIFO across the edge that pops it: must be refused
        ready = 1'b1;
        a_valid = 1'b1;
        a_cmd = 32'hDEAD_BEEF;
        step();
        chk("x1_lo_A", 32'(ctrlA), 32'h00FF);
        chk("x1_lo_B", 32'(ctrlB), 32'hB100);
        chk("x1_level", 32'(a_level), 4);
        chk("x1_a_ready", 32'(a_ready), 0);
        step();
        a_valid = 1'b0;
        chk("x2_a_level", 32'(a_level), 3);
        chk("x2_b_level", 32'(b_level), 3);
        chk("x2_a_ready", 32'(a_ready), 1);
        chk("x2_sent", 32'(sent_cnt), 2);
        chk("x2_up_A", 32'(ctrlA), 32'hA001);
        chk("x2_req", 32'(req), 1);
        for (int k = 1; k < 5; k++) begin
            step();
            chk("b2b_lo_A", 32'(ctrlA), {16'h0, 8'hA1, 8'(k)});
            chk("b2b_lo_B", 32'(ctrlB), {16'h0, 8'hB1, 8'(k)});
            chk("b2b_lo_req", 32'(req), 1);
            step();
            chk("b2b_sent", 32'(sent_cnt), 32'(k + 2));
            if (k < 4) begin
                chk("b2b_up_A", 32'(ctrlA), {16'h0, 8'hA0, 8'(k + 1)});
                chk("b2b_up_B", 32'(ctrlB), {16'h0, 8'hB0, 8'(k + 1)});
                chk("b2b_up_req", 32'(req), 1);
            end else begin
                chk("b2b_end_req", 32'(req), 0);
                chk("b2b_end_busy", 32'(busy), 0);
                chk("b2b_end_level", 32'(a_level), 0);
            end
        end

        // reset while the upper beat is on the bus
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_cmd = 32'h1357_9BDF;
        b_cmd = 32'h2468_ACE0;
        step();
        a_cmd = 32'h1111_2222;
        b_cmd = 32'h3333_4444;
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("r_up_A", 32'(ctrlA), 32'h1357);
        chk("r_up_B", 32'(ctrlB), 32'h2468);
        chk("r_level", 32'(a_level), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("r_req", 32'(req), 0);
        chk("r_a_level", 32'(a_level), 0);
        chk("r_b_level", 32'(b_level), 0);
        chk("r_sent", 32'(sent_cnt), 0);
        chk("r_ctrlA", 32'(ctrlA), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r_no_lower", 32'(req), 0);
        end
        chk("r_sent_after", 32'(sent_cnt), 0);

`ifdef ATS21_CMD_TIMEOUT_EN
        // timeout abort, then the next queued pair goes out normally
        ready = 1'b0;
        a_valid = 1'b1;
        a_cmd = 32'h0123_4567;
        step();
        a_cmd = 32'h89AB_CDEF;
        step();
        a_valid = 1'b0;
        chk("t_req", 32'(req), 1);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("t_no_err", 32'(err), 0);
            chk("t_hold", 32'(ctrlA), 32'h0123);
        end
        step();
        chk("t_err", 32'(err), 1);
        chk("t_req0", 32'(req), 0);
        chk("t_busy", 32'(busy), 0);
        chk("t_sent", 32'(sent_cnt), 0);
        step();
        chk("t_err_once", 32'(err), 0);
        chk("t_next_A", 32'(ctrlA), 32'h89AB);
        ready = 1'b1;
        step();
        chk("t_next_lo", 32'(ctrlA), 32'hCDEF);
        step();
        chk("t_next_sent", 32'(sent_cnt), 1);
        chk("t_err_clear", 32'(err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ats21_cmd_issuer.md
# ats21_cmd_issuer

Initiator side of the ATS21 alarm/timer command interface. Buffers 32-bit commands for channel A and channel B in two independent FIFOs. Pairs the FIFO heads and transfers each pair to the ATS21 responder as two 16-bit beats (upper half, then lower half) over a req/ready handshake. Sits between the host/sequencer and the ATS21 core; an empty channel is padded with a NOP.

## Interface
- DEPTH, 4, entries per channel FIFO; power of 2, ≥2
- TIMEOUT, 255, consecutive ready-low cycles tolerated per beat; used only with ATS21_CMD_TIMEOUT_EN
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- a_valid  in  1  channel A command push request
- a_cmd  in  32  channel A command; [31:29] opcode, rest opcode-defined
- a_ready  out  1  channel A FIFO not full; push occurs on a_valid && a_ready
- b_valid  in  1  channel B command push request
- b_cmd  in  32  channel B command
- b_ready  out  1  channel B FIFO not full
- req  out  1  beat valid toward responder
- ctrlA  out  16  channel A half-word of current beat
- ctrlB  out  16  channel B half-word of current beat
- ready  in  1  responder accepts beat; a beat transfers on req && ready at posedge clk
- busy  out  1  state != IDLE
- a_level  out  $clog2(DEPTH)+1  channel A FIFO occupancy
- b_level  out  $clog2(DEPTH)+1  channel B FIFO occupancy
- sent_cnt  out  16  completed command pairs; wraps 16'hFFFF -> 0
- err  out  1  one-cycle timeout abort pulse; constant 0 without ATS21_CMD_TIMEOUT_EN

## Operation
- FSM states: IDLE, UPPER, LOWER.
- IDLE: if either FIFO is non-empty, pop both non-empty heads into holding regs hA/hB. An empty channel loads 32'h0000_0000 (NOP) and is not popped. Go to UPPER.
- UPPER: req=1, ctrlA=hA[31:16], ctrlB=hB[31:16]. On ready, go to LOWER.
- LOWER: req=1, ctrlA=hA[15:0], ctrlB=hB[15:0]. On ready, increment sent_cnt.
  - If either FIFO is non-empty on that edge, load the next pair and go directly to UPPER (back-to-back, no req gap).
  - Otherwise go to IDLE.
- IDLE outputs: req=0, ctrlA=ctrlB=0.
- req, ctrlA and ctrlB are registered. Beats hold stable while ready is low.
- A NOP pair is never generated when both FIFOs are empty.
- FIFOs:
  - Push ignored when full (a_ready/b_ready low).
  - Push and pop of the same FIFO on one edge: level unchanged, order preserved.
  - A push to an empty FIFO is not poppable on the same edge.
- Reset values: req=0, ctrlA=0, ctrlB=0, busy=0, a_ready=b_ready=1, a_level=b_level=0, sent_cnt=0, err=0. FSM goes to IDLE and hA/hB clear.
- Reset mid-transfer: pending pair discarded, FIFOs flushed, req low after the reset edge. sent_cnt does not count the discarded pair.

## Timing
- Push at edge E into empty FIFO with FSM IDLE:
  - req and upper halves visible after edge E+1.
  - With ready held high: upper beat accepted at E+2, lower at E+3.
  - sent_cnt updates after E+3.
- Back-to-back throughput: one pair per 2 cycles with ready high.
- ready low stalls the FSM indefinitely (macro off).
- a_level/b_level/a_ready/b_ready are registered, reflecting state after each edge.

## Configuration
- ATS21_CMD_TIMEOUT_EN defined:
  - A counter runs in UPPER/LOWER while req && !ready, and clears on every accepted beat and on state entry.
  - When the count reaches TIMEOUT, on that edge: the pair is abandoned, the FSM goes to IDLE, err=1 for one cycle, sent_cnt is unchanged, and req=0 the next cycle.
  - If ready rises on the same edge the count reaches TIMEOUT, the beat is accepted and there is no abort.
- Undefined: no counter, err tied 0, infinite wait.

## Structure
- ats21_pkg holds:
  - opcode_t enum: NOP=3'b000, SET_CLK=3'b001, CLK_EN=3'b010, SET_MODE=3'b011, SET_ALARM=3'b101, SET_TIMER=3'b110, AT_EN=3'b111
  - NOP_CMD = 32'h0
  - issuer_state_t {IDLE, UPPER, LOWER}
- Sub-module ats21_cmd_fifo (parameter DEPTH, WIDTH=32) with push/pop/full/empty/level, instantiated once per channel.

## Test plan
- Single A command 32'h2A00_1234, B empty, ready=1:
  - beats (A,B) = (16'h2A00, 0) then (16'h1234, 0);
  - sent_cnt=1; busy low after the lower beat.
- Four A and four B commands pushed back-to-back, DEPTH=4, ready=1:
  - a_ready low after the 4th push;
  - 8 beats on consecutive cycles with no req gap;
  - order preserved; sent_cnt=4.
- ready held low 10 cycles during the upper beat of 32'h5F80_00FF:
  - ctrlA stays 16'h5F80 and req stays 1 throughout;
  - transfer completes after ready rises.
- Push on a full FIFO while a pop occurs on the same edge:
  - the push is refused (a_ready=0);
  - level drops by 1; no entry is lost or duplicated.
- Reset asserted between the upper and lower beats:
  - next cycle req=0, levels=0, sent_cnt=0;
  - no lower beat is ever driven.
- With ATS21_CMD_TIMEOUT_EN and TIMEOUT=8, ready held low:
  - err pulses exactly once, on the 8th stall cycle;
  - FSM returns to IDLE and sent_cnt is unchanged;
  - the next queued pair is issued normally.
